// File: rtl/nr_iter_ctrl.sv
// Newton-Raphson iteration controller: launches gen_iteration passes, captures results and stops on ULP convergence or MAX_ITER.
// Optional NaN abort is enabled by defining NR_NAN_ABORT_EN.
module nr_iter_ctrl #(
    parameter int MAX_ITER = 32,
    parameter int ULP_TOL  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] init_x0,
    input  logic [31:0] init_x1,
    input  logic [31:0] init_x2,
    input  logic [31:0] init_invJ0,
    input  logic [31:0] init_invJ1,
    input  logic [31:0] init_invJ2,
    input  logic [31:0] init_invJ3,
    input  logic [31:0] init_invJ4,
    input  logic [31:0] init_invJ5,
    input  logic [31:0] init_invJ6,
    input  logic [31:0] init_invJ7,
    input  logic [31:0] init_invJ8,
    input  logic [31:0] init_invJ9,
    input  logic [31:0] init_invJ10,
    input  logic [31:0] init_invJ11,
    input  logic [31:0] gen_x0,
    input  logic [31:0] gen_x1,
    input  logic [31:0] gen_x2,
    input  logic [31:0] gen_invJ0,
    input  logic [31:0] gen_invJ1,
    input  logic [31:0] gen_invJ2,
    input  logic [31:0] gen_invJ3,
    input  logic [31:0] gen_invJ4,
    input  logic [31:0] gen_invJ5,
    input  logic [31:0] gen_invJ6,
    input  logic [31:0] gen_invJ7,
    input  logic [31:0] gen_invJ8,
    input  logic [31:0] gen_invJ9,
    input  logic [31:0] gen_invJ10,
    input  logic [31:0] gen_invJ11,
    input  logic        gen_stb,
    output logic        gen_rst,
    output logic [31:0] x0,
    output logic [31:0] x1,
    output logic [31:0] x2,
    output logic [31:0] invJ0,
    output logic [31:0] invJ1,
    output logic [31:0] invJ2,
    output logic [31:0] invJ3,
    output logic [31:0] invJ4,
    output logic [31:0] invJ5,
    output logic [31:0] invJ6,
    output logic [31:0] invJ7,
    output logic [31:0] invJ8,
    output logic [31:0] invJ9,
    output logic [31:0] invJ10,
    output logic [31:0] invJ11,
    output logic        busy,
    output logic        done,
    output logic        converged,
    output logic        nan_flag,
    output logic [7:0]  iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] x_q     [3];
    logic [31:0] x_d     [3];
    logic [31:0] new_x_q [3];
    logic [31:0] new_x_d [3];
    logic [31:0] invj_q  [12];
    logic [31:0] invj_d  [12];
    logic [7:0]  iter_q, iter_d;
    logic        conv_q, conv_d;
    logic        gen_rst_q, gen_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        all_match;

    logic [31:0] init_x_a    [3];
    logic [31:0] init_invj_a [12];
    logic [31:0] gen_x_a     [3];
    logic [31:0] gen_invj_a  [12];

    assign init_x_a    = '{init_x0, init_x1, init_x2};
    assign init_invj_a = '{init_invJ0, init_invJ1, init_invJ2, init_invJ3,
                           init_invJ4, init_invJ5, init_invJ6, init_invJ7,
                           init_invJ8, init_invJ9, init_invJ10, init_invJ11};
    assign gen_x_a     = '{gen_x0, gen_x1, gen_x2};
    assign gen_invj_a  = '{gen_invJ0, gen_invJ1, gen_invJ2, gen_invJ3,
                           gen_invJ4, gen_invJ5, gen_invJ6, gen_invJ7,
                           gen_invJ8, gen_invJ9, gen_invJ10, gen_invJ11};

    // +0 and -0 are equal; otherwise same sign and magnitude bits within ULP_TOL
    function automatic logic ulp_match(input logic [31:0] a, input logic [31:0] b);
        logic [30:0] diff;
        diff = (a[30:0] >= b[30:0]) ? (a[30:0] - b[30:0]) : (b[30:0] - a[30:0]);
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
            return 1'b1;
        end
        return (a[31] == b[31]) && (diff <= 31'(ULP_TOL));
    endfunction

`ifdef NR_NAN_ABORT_EN
    logic nan_q, nan_d;
    logic any_nan;
`endif

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        new_x_d   = new_x_q;
        invj_d    = invj_q;
        iter_d    = iter_q;
        conv_d    = conv_q;
        all_match = ulp_match(new_x_q[0], x_q[0]) &&
                    ulp_match(new_x_q[1], x_q[1]) &&
                    ulp_match(new_x_q[2], x_q[2]);
`ifdef NR_NAN_ABORT_EN
        nan_d     = nan_q;
        any_nan   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((new_x_q[i][30:23] == 8'hFF) && (new_x_q[i][22:0] != 23'd0)) begin
                any_nan = 1'b1;
            end
        end
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    x_d     = init_x_a;
                    invj_d  = init_invj_a;
                    iter_d  = 8'd0;
                    conv_d  = 1'b0;
`ifdef NR_NAN_ABORT_EN
                    nan_d   = 1'b0;
`endif
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (gen_stb) begin
                    new_x_d = gen_x_a;
                    invj_d  = gen_invj_a;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                iter_d = iter_q + 8'd1;
`ifdef NR_NAN_ABORT_EN
                if (any_nan) begin
                    nan_d   = 1'b1;
                    conv_d  = 1'b0;
                    state_d = S_DONE;
                end else
`endif
                begin
                    x_d = new_x_q;
                    if (all_match) begin
                        conv_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (iter_d == 8'(MAX_ITER)) begin
                        conv_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Status outputs are registered from the next state so they line up with it
        gen_rst_d = (state_d != S_WAIT);
        busy_d    = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < 3; i++) begin
                x_q[i]     <= 32'd0;
                new_x_q[i] <= 32'd0;
            end
            for (int k = 0; k < 12; k++) begin
                invj_q[k] <= 32'd0;
            end
            iter_q    <= 8'd0;
            conv_q    <= 1'b0;
            gen_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef NR_NAN_ABORT_EN
            nan_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            new_x_q   <= new_x_d;
            invj_q    <= invj_d;
            iter_q    <= iter_d;
            conv_q    <= conv_d;
            gen_rst_q <= gen_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef NR_NAN_ABORT_EN
            nan_q     <= nan_d;
`endif
        end
    end

`ifdef NR_NAN_ABORT_EN
    assign nan_flag = nan_q;
`else
    assign nan_flag = 1'b0;
`endif

    assign gen_rst    = gen_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign converged  = conv_q;
    assign iter_count = iter_q;
    assign x0         = x_q[0];
    assign x1         = x_q[1];
    assign x2         = x_q[2];
    assign invJ0      = invj_q[0];
    assign invJ1      = invj_q[1];
    assign invJ2      = invj_q[2];
    assign invJ3      = invj_q[3];
    assign invJ4      = invj_q[4];
    assign invJ5      = invj_q[5];
    assign invJ6      = invj_q[6];
    assign invJ7      = invj_q[7];
    assign invJ8      = invj_q[8];
    assign invJ9      = invj_q[9];
    assign invJ10     = invj_q[10];
    assign invJ11     = invj_q[11];

endmodule

// File: tb/tb_nr_iter_ctrl.sv
// Scoreboard bench for nr_iter_ctrl with a behavioural gen_iteration model (fixed 5-cycle latency).
module tb_nr_iter_ctrl;

    localparam int MAX_ITER = 4;

    typedef struct {
        logic        conv;
        logic        nanf;
        logic [7:0]  iter;
        logic [31:0] x0;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] j0;
        int          launches;
        int          base;
    } exp_t;

    typedef struct {
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] init_x    [3];
    logic [31:0] init_invj [12];
    logic [31:0] gen_x     [3];
    logic [31:0] gen_invj  [12];
    logic        gen_stb;
    logic        gen_rst;
    logic [31:0] x_o       [3];
    logic [31:0] invj_o    [12];
    logic        busy;
    logic        done;
    logic        converged;
    logic        nan_flag;
    logic [7:0]  iter_count;

    int     checks   = 0;
    int     failures = 0;
    int     launches = 0;
    int     mode     = 0;
    int     wcnt     = 0;
    logic   force_stb = 1'b0;
    logic   done_prev = 1'b0;
    logic   gen_rst_prev = 1'b1;
    exp_t   expQ [$];
    resp_t  respQ [$];
    resp_t  r;
    exp_t   em;

    always #5 clk = ~clk;

    nr_iter_ctrl #(.MAX_ITER(MAX_ITER), .ULP_TOL(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .init_x0(init_x[0]), .init_x1(init_x[1]), .init_x2(init_x[2]),
        .init_invJ0(init_invj[0]), .init_invJ1(init_invj[1]), .init_invJ2(init_invj[2]),
        .init_invJ3(init_invj[3]), .init_invJ4(init_invj[4]), .init_invJ5(init_invj[5]),
        .init_invJ6(init_invj[6]), .init_invJ7(init_invj[7]), .init_invJ8(init_invj[8]),
        .init_invJ9(init_invj[9]), .init_invJ10(init_invj[10]), .init_invJ11(init_invj[11]),
        .gen_x0(gen_x[0]), .gen_x1(gen_x[1]), .gen_x2(gen_x[2]),
        .gen_invJ0(gen_invj[0]), .gen_invJ1(gen_invj[1]), .gen_invJ2(gen_invj[2]),
        .gen_invJ3(gen_invj[3]), .gen_invJ4(gen_invj[4]), .gen_invJ5(gen_invj[5]),
        .gen_invJ6(gen_invj[6]), .gen_invJ7(gen_invj[7]), .gen_invJ8(gen_invj[8]),
        .gen_invJ9(gen_invj[9]), .gen_invJ10(gen_invj[10]), .gen_invJ11(gen_invj[11]),
        .gen_stb(gen_stb), .gen_rst(gen_rst),
        .x0(x_o[0]), .x1(x_o[1]), .x2(x_o[2]),
        .invJ0(invj_o[0]), .invJ1(invj_o[1]), .invJ2(invj_o[2]), .invJ3(invj_o[3]),
        .invJ4(invj_o[4]), .invJ5(invj_o[5]), .invJ6(invj_o[6]), .invJ7(invj_o[7]),
        .invJ8(invj_o[8]), .invJ9(invj_o[9]), .invJ10(invj_o[10]), .invJ11(invj_o[11]),
        .busy(busy), .done(done), .converged(converged), .nan_flag(nan_flag),
        .iter_count(iter_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // gen_iteration model: mode 0 pops respQ (or echoes x), 1 adds 100 ULP, 2 never answers, 3 random
    always @(negedge clk) begin
        gen_stb = 1'b0;
        if (mode == 3) begin
            gen_stb = 1'($urandom_range(0, 1));
            for (int i = 0; i < 3; i++) gen_x[i] = $urandom;
            for (int k = 0; k < 12; k++) gen_invj[k] = $urandom;
        end else if (force_stb) begin
            gen_stb = 1'b1;
        end else if (rst && !gen_rst) begin
            if (mode != 2 && wcnt == 4) begin
                wcnt = 0;
                if (mode == 1) begin
                    for (int i = 0; i < 3; i++) gen_x[i] = x_o[i] + 32'd100;
                end else if (respQ.size() > 0) begin
                    r = respQ.pop_front();
                    gen_x[0] = r.v0;
                    gen_x[1] = r.v1;
                    gen_x[2] = r.v2;
                end else begin
                    for (int i = 0; i < 3; i++) gen_x[i] = x_o[i];
                end
                for (int k = 0; k < 12; k++) gen_invj[k] = invj_o[k] + 32'd1;
                gen_stb = 1'b1;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: counts launches and scores each completed solve against the queue
    always @(negedge clk) begin
        if (!rst) begin
            done_prev    = 1'b0;
            gen_rst_prev = 1'b1;
        end else begin
            if (gen_rst_prev && !gen_rst) launches++;
            gen_rst_prev = gen_rst;
            if (done && !done_prev) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done actual=1 required=0");
                end else begin
                    em = expQ.pop_front();
                    checkOutput("converged", 32'(converged), 32'(em.conv));
                    checkOutput("nan_flag", 32'(nan_flag), 32'(em.nanf));
                    checkOutput("iter_count", 32'(iter_count), 32'(em.iter));
                    checkOutput("x0", x_o[0], em.x0);
                    checkOutput("x1", x_o[1], em.x1);
                    checkOutput("x2", x_o[2], em.x2);
                    checkOutput("invJ0", invj_o[0], em.j0);
                    checkOutput("launches", 32'(launches - em.base), 32'(em.launches));
                    checkOutput("busy_in_done", 32'(busy), 32'd0);
                end
            end
            done_prev = done;
        end
    end

    task automatic applyStimulus(input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input exp_t e);
        int n;
        @(negedge clk);
        init_x[0] = a0;
        init_x[1] = a1;
        init_x[2] = a2;
        e.base = launches;
        expQ.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL solve_timeout actual=%0d cycles required=done", n);
            expQ.delete();
        end
        @(negedge clk);
    endtask

    function automatic exp_t mk(input logic c, input logic nf, input logic [7:0] it,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input int passes);
        exp_t e;
        e.conv = c;
        e.nanf = nf;
        e.iter = it;
        e.x0 = e0;
        e.x1 = e1;
        e.x2 = e2;
        e.j0 = 32'h3f000000 + 32'(passes);
        e.launches = passes;
        e.base = 0;
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst   = 1'b0;
        start = 1'b0;
        mode  = 3;
        for (int i = 0; i < 3; i++) init_x[i] = $urandom;
        for (int k = 0; k < 12; k++) init_invj[k] = $urandom;
        repeat (6) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
        end
        checkOutput("rst_gen_rst", 32'(gen_rst), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_converged", 32'(converged), 32'd0);
        checkOutput("rst_nan_flag", 32'(nan_flag), 32'd0);
        checkOutput("rst_iter", 32'(iter_count), 32'd0);
        checkOutput("rst_x0", x_o[0], 32'd0);
        checkOutput("rst_invJ11", invj_o[11], 32'd0);

        start = 1'b0;
        mode  = 0;
        for (int k = 0; k < 12; k++) init_invj[k] = 32'h3f000000 + 32'(k);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Immediate convergence
        respQ.delete();
        applyStimulus(32'h3f800000, 32'h40000000, 32'h40400000,
                      mk(1, 0, 1, 32'h3f800000, 32'h40000000, 32'h40400000, 1));
        // +16 ULP is inside tolerance
        respQ.delete();
        respQ.push_back('{32'h3f800010, 32'h40000000, 32'h40400000});
        applyStimulus(32'h3f800000, 32'h40000000, 32'h40400000,
                      mk(1, 0, 1, 32'h3f800010, 32'h40000000, 32'h40400000, 1));
        // +17 ULP fails, second pass identical converges
        respQ.delete();
        respQ.push_back('{32'h3f800011, 32'h40000000, 32'h40400000});
        applyStimulus(32'h3f800000, 32'h40000000, 32'h40400000,
                      mk(1, 0, 2, 32'h3f800011, 32'h40000000, 32'h40400000, 2));
        // +0 vs -0 match
        respQ.delete();
        respQ.push_back('{32'h80000000, 32'h3f800000, 32'h40000000});
        applyStimulus(32'h00000000, 32'h3f800000, 32'h40000000,
                      mk(1, 0, 1, 32'h80000000, 32'h3f800000, 32'h40000000, 1));
        // Opposite signs mismatch
        respQ.delete();
        respQ.push_back('{32'hbf800000, 32'h40000000, 32'h40400000});
        applyStimulus(32'h3f800000, 32'h40000000, 32'h40400000,
                      mk(1, 0, 2, 32'hbf800000, 32'h40000000, 32'h40400000, 2));
        // Negative values, 15 ULP apart
        respQ.delete();
        respQ.push_back('{32'hc000000f, 32'h40000000, 32'h40400000});
        applyStimulus(32'hc0000000, 32'h40000000, 32'h40400000,
                      mk(1, 0, 1, 32'hc000000f, 32'h40000000, 32'h40400000, 1));
        // Iteration limit: 4 passes of +100 ULP
        mode = 1;
        applyStimulus(32'h3f800000, 32'h40000000, 32'h40400000,
                      mk(0, 0, 4, 32'h3f800190, 32'h40000190, 32'h40400190, 4));
        mode = 0;
        // NaN returned in x1
        respQ.delete();
        respQ.push_back('{32'h3f800000, 32'h7fc00000, 32'h40400000});
        respQ.push_back('{32'h3f800000, 32'h7fc00000, 32'h40400000});
`ifdef NR_NAN_ABORT_EN
        applyStimulus(32'h3f800000, 32'h40000000, 32'h40400000,
                      mk(0, 1, 1, 32'h3f800000, 32'h40000000, 32'h40400000, 1));
`else
        applyStimulus(32'h3f800000, 32'h40000000, 32'h40400000,
                      mk(1, 0, 2, 32'h3f800000, 32'h7fc00000, 32'h40400000, 2));
`endif

        // Reset during WAIT, then a stray gen_stb while idle
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (gen_rst && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_wait", 32'(gen_rst), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_gen_rst", 32'(gen_rst), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_x0", x_o[0], 32'd0);
        checkOutput("midrst_iter", 32'(iter_count), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        force_stb = 1'b1;
        repeat (2) @(negedge clk);
        force_stb = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stray_stb_busy", 32'(busy), 32'd0);
        checkOutput("stray_stb_done", 32'(done), 32'd0);
        checkOutput("stray_stb_x0", x_o[0], 32'd0);
        checkOutput("stray_stb_invJ0", invj_o[0], 32'd0);
        checkOutput("stray_stb_gen_rst", 32'(gen_rst), 32'd1);

        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL pending_expectations actual=%0d required=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nr_iter_ctrl.md
# nr_iter_ctrl

Iteration controller for the Newton–Raphson datapath, sitting directly around `gen_iteration`: it loads the initial estimate and inverse Jacobian, launches one `gen_iteration` pass, and captures `out_x*`/`next_invJ*` on `output_stb`. After each pass it tests convergence with a per-component ULP-distance check and either feeds the captured values back for another pass or stops. It reports the final estimate, iteration count and termination status to the system.

## Interface
- `MAX_ITER`, 32: maximum passes before forced stop (1..255).
- `ULP_TOL`, 16: maximum allowed |Δ| per component, in units of single-precision bit pattern.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: pulse to begin a solve; sampled only in IDLE or DONE.
- `init_x0..init_x2` in 32 each: initial estimate, IEEE-754 single.
- `init_invJ0..init_invJ11` in 32 each: initial inverse-Jacobian words, IEEE-754 single.
- `gen_x0..gen_x2` in 32 each: from `gen_iteration` `out_x*`.
- `gen_invJ0..gen_invJ11` in 32 each: from `gen_iteration` `next_invJ*`.
- `gen_stb` in 1: from `gen_iteration` `output_stb`.
- `gen_rst` out 1: active-high restart to `gen_iteration`; held high except during a pass.
- `x0..x2` out 32 each: working estimate; drives `gen_iteration` `in_x*`; final result in DONE.
- `invJ0..invJ11` out 32 each: working inverse Jacobian; drives `gen_iteration` `invJ*`.
- `busy` out 1: high in LAUNCH, WAIT, CHECK.
- `done` out 1: high in DONE.
- `converged` out 1: valid when `done`; 1 = ULP test passed.
- `nan_flag` out 1: valid when `done`; 1 = aborted on NaN.
- `iter_count` out 8: completed passes in current solve.

## Operation
- States: IDLE, LAUNCH, WAIT, CHECK, DONE.
- IDLE/DONE + `start`: load `x*`←`init_x*`, `invJ*`←`init_invJ*`, clear `iter_count`, `converged`, `nan_flag`; go LAUNCH.
- LAUNCH (1 cycle): `gen_rst`=1; go WAIT.
- WAIT: `gen_rst`=0. On `gen_stb`=1: capture `gen_x*` into `new_x*` and `gen_invJ*` into `invJ*`; go CHECK. `gen_stb` outside WAIT is ignored.
- CHECK (1 cycle): `iter_count`+1; compare `new_x*` vs `x*`; then `x*`←`new_x*`.
  - Component match: both are ±0; or sign bits equal and |a[30:0]−b[30:0]| ≤ `ULP_TOL` (31-bit unsigned difference, no wrap).
  - All three match → DONE, `converged`=1.
  - Else `iter_count`+1 == `MAX_ITER` → DONE, `converged`=0.
  - Else → LAUNCH.
- DONE: outputs hold until next `start`.
- `start` while `busy` is ignored.

## Timing
- Reset values: state IDLE, all `x*`/`invJ*` 0, `gen_rst`=1, `busy`/`done`/`converged`/`nan_flag`=0, `iter_count`=0.
- `start` sampled at edge N → `busy`=1 and LAUNCH at N+1; `gen_rst` low from N+2.
- `gen_stb` sampled at edge M → CHECK at M+1 → next LAUNCH or DONE at M+2.
- Per-pass overhead: 3 cycles plus `gen_iteration` latency.
- Reset asserted mid-solve: immediate return to reset values; the in-flight pass is discarded.
- `gen_stb` asserted in the same cycle as LAUNCH is ignored.

## Configuration
- `NR_NAN_ABORT_EN` defined: in CHECK, if any `new_x*` has exponent 8'hFF and mantissa ≠ 0, go DONE with `nan_flag`=1, `converged`=0, and `x*` keeping the last non-NaN estimate. This check takes priority over the convergence and limit checks.
- Undefined: no NaN detection; `nan_flag` tied 0; NaN patterns go through the ULP test like any other bits.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs at reset values, `gen_rst`=1.
- Immediate convergence: init_x = {3f800000, 40000000, 40400000}; model returns the same x after 5 cycles → `done`, `converged`=1, `iter_count`=1, x unchanged.
- ULP boundary: returned x0 = init+16 ULP → converged. Rerun with +17 ULP, then identical values → converged, `iter_count`=2.
- Sign/zero: 00000000 vs 80000000 → match. 3f800000 vs bf800000 → mismatch.
- Limit: `MAX_ITER`=4; model always adds 100 ULP → `done`, `converged`=0, `iter_count`=4, and exactly 4 `gen_rst` launch pulses.
- NaN and reset mid-run (with `NR_NAN_ABORT_EN`): model returns x1=7fc00000 → `nan_flag`=1, x1 holds previous value. Separately, pulse `rst` low during WAIT → IDLE; a following `gen_stb` is ignored.
